// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: memory geometry,
// reset PC, bubble encoding and FSM state type.
package fetch_unit_pkg;

  localparam int              PC_W       = 32;
  localparam int              IMEM_DEPTH = 32;
  localparam logic [PC_W-1:0] RESET_PC   = '0;
  localparam logic [31:0]     NOP_INST   = 32'h0000_0000;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: jump > taken branch > stall > PC+1.
// Redirects only count when the IF/ID register holds a real instruction.
module pc_next_sel
  import fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] ifid_pc_plus1,
  input  logic            ifid_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  output logic [PC_W-1:0] pc_next,
  output logic            redirect
);

  always_comb begin
    pc_next  = pc + PC_W'(1);
    redirect = 1'b0;
    if (ifid_valid && jump) begin
      redirect = 1'b1;
      pc_next  = {ifid_pc_plus1[PC_W-1:26], jump_target};
    end else if (ifid_valid && branch_taken) begin
      redirect = 1'b1;
      pc_next  = ifid_pc_plus1 + {{(PC_W-16){branch_offset[15]}}, branch_offset};
    end else if (stall) begin
      pc_next  = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register and the
// START/RUN/HALT sequencing; halts once the PC leaves instruction memory.
module fetch_unit
  #(
    parameter int          IMEM_DEPTH = fetch_unit_pkg::IMEM_DEPTH,
    parameter logic [31:0] RESET_PC   = fetch_unit_pkg::RESET_PC
  )
  (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus1,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
  );

  import fetch_unit_pkg::*;

  localparam logic [PC_W-1:0] DEPTH_W = PC_W'(IMEM_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;
  logic [PC_W-1:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic [PC_W-1:0] sel_pc;
  logic            redirect;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .ifid_pc_plus1 (ifid_pc_plus1_q),
    .ifid_valid    (ifid_valid_q),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_next       (sel_pc),
    .redirect      (redirect)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_inst_d     = ifid_inst_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;
    case (state_q)
      START: state_d = RUN;
      RUN: begin
        // A redirect wins even over the end-of-memory check, so an
        // out-of-range target is taken first and halts one cycle later.
        if (redirect) begin
          pc_d         = sel_pc;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
        end else if (pc_q >= DEPTH_W) begin
          state_d      = HALT;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d            = sel_pc;
          ifid_inst_d     = imem_inst;
          ifid_pc_plus1_d = pc_q + PC_W'(1);
          ifid_valid_d    = 1'b1;
          fetch_count_d   = fetch_count_q + 32'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= START;
      pc_q            <= RESET_PC;
      ifid_inst_q     <= NOP_INST;
      ifid_pc_plus1_q <= '0;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_inst_q     <= ifid_inst_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign ifid_valid    = ifid_valid_q;
  assign halted        = (state_q == HALT);
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural instruction
// memory holding 0xA0+addr in every legal word.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] imem_addr, imem_inst, ifid_inst, ifid_pc_plus1, fetch_count;
  logic        ifid_valid, halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_halt;
    logic [31:0] e_pc;
    logic [31:0] e_pp1;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .ifid_inst     (ifid_inst),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  always_comb imem_inst = (imem_addr < 32'd32) ? (32'hA0 + imem_addr) : 32'hDEAD_BEEF;

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] o,
                              input logic j, input logic [25:0] t,
                              input logic [31:0] ei, input logic ev, input logic eh,
                              input logic [31:0] ep, input logic [31:0] epp,
                              input logic [31:0] ec);
    vec_t v;
    v.stall = s; v.br = b; v.off = o; v.jmp = j; v.jt = t;
    v.e_inst = ei; v.e_valid = ev; v.e_halt = eh;
    v.e_pc = ep; v.e_pp1 = epp; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check_output({tag, " ifid_inst"},     ifid_inst,            v.e_inst);
    check_output({tag, " ifid_valid"},    {31'd0, ifid_valid},  {31'd0, v.e_valid});
    check_output({tag, " halted"},        {31'd0, halted},      {31'd0, v.e_halt});
    check_output({tag, " imem_addr"},     imem_addr,            v.e_pc);
    check_output({tag, " ifid_pc_plus1"}, ifid_pc_plus1,        v.e_pp1);
    check_output({tag, " fetch_count"},   fetch_count,          v.e_cnt);
  endtask

  // Drive one cycle of inputs, take one rising edge, then check just after it.
  task automatic apply_stimulus(input string tag, input vec_t v);
    stall         = v.stall;
    branch_taken  = v.br;
    branch_offset = v.off;
    jump          = v.jmp;
    jump_target   = v.jt;
    @(posedge clock);
    #1;
    check_all(tag, v);
  endtask

  initial begin
    vec_t rst_v;
    rst_v = mk(0, 0, 16'h0, 0, 26'd0, 32'h0, 0, 0, 32'd0, 32'd0, 32'd0);

    reset_n = 1'b0;
    stall = 0; branch_taken = 0; branch_offset = '0; jump = 0; jump_target = '0;

    //                stall br  off       jmp jt      inst      v  h  pc      pp1     cnt
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'h00, 0, 0, 32'd0,  32'd0,  32'd0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA0, 1, 0, 32'd1,  32'd1,  32'd1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA1, 1, 0, 32'd2,  32'd2,  32'd2));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA2, 1, 0, 32'd3,  32'd3,  32'd3));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA3, 1, 0, 32'd4,  32'd4,  32'd4));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA4, 1, 0, 32'd5,  32'd5,  32'd5));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA5, 1, 0, 32'd6,  32'd6,  32'd6));
    vecs.push_back(mk(0, 1, 16'h0005, 1, 26'd20, 32'h00, 0, 0, 32'd20, 32'd6,  32'd6));
    vecs.push_back(mk(0, 1, 16'hFFFD, 0, 26'd0,  32'hB4, 1, 0, 32'd21, 32'd21, 32'd7));
    vecs.push_back(mk(1, 1, 16'hFFED, 0, 26'd0,  32'h00, 0, 0, 32'd2,  32'd21, 32'd7));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA2, 1, 0, 32'd3,  32'd3,  32'd8));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 26'd0,  32'hA2, 1, 0, 32'd3,  32'd3,  32'd8));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 26'd0,  32'hA2, 1, 0, 32'd3,  32'd3,  32'd8));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 26'd0,  32'hA2, 1, 0, 32'd3,  32'd3,  32'd8));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA3, 1, 0, 32'd4,  32'd4,  32'd9));
    vecs.push_back(mk(1, 1, 16'hFFFD, 0, 26'd0,  32'h00, 0, 0, 32'd1,  32'd4,  32'd9));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hA1, 1, 0, 32'd2,  32'd2,  32'd10));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 26'd30, 32'h00, 0, 0, 32'd30, 32'd2,  32'd10));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hBE, 1, 0, 32'd31, 32'd31, 32'd11));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 26'd0,  32'hBF, 1, 0, 32'd32, 32'd32, 32'd12));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 26'd0,  32'h00, 0, 1, 32'd32, 32'd32, 32'd12));
    vecs.push_back(mk(0, 1, 16'hFFF6, 1, 26'd3,  32'h00, 0, 1, 32'd32, 32'd32, 32'd12));
    vecs.push_back(mk(0, 1, 16'h0002, 0, 26'd0,  32'h00, 0, 1, 32'd32, 32'd32, 32'd12));

    #12;
    check_all("reset", rst_v);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset while halted, between clock edges.
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", rst_v);
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus("post_rst_edge1", mk(0, 0, 16'h0, 0, 26'd0,  32'h00, 0, 0, 32'd0,  32'd0, 32'd0));
    apply_stimulus("post_rst_edge2", mk(0, 0, 16'h0, 0, 26'd0,  32'hA0, 1, 0, 32'd1,  32'd1, 32'd1));

    // Jump out of range is taken, then the halt follows a cycle later.
    apply_stimulus("jump_oob",       mk(0, 0, 16'h0, 1, 26'd40, 32'h00, 0, 0, 32'd40, 32'd1, 32'd1));
    apply_stimulus("halt_after_oob", mk(0, 0, 16'h0, 0, 26'd0,  32'h00, 0, 1, 32'd40, 32'd1, 32'd1));

    // Reset asserted in the middle of a stall, away from the edge.
    reset_n = 1'b0;
    #2;
    check_all("rst_reload", rst_v);
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus("reload_edge1", mk(0, 0, 16'h0, 0, 26'd0, 32'h00, 0, 0, 32'd0, 32'd0, 32'd0));
    apply_stimulus("reload_edge2", mk(0, 0, 16'h0, 0, 26'd0, 32'hA0, 1, 0, 32'd1, 32'd1, 32'd1));
    apply_stimulus("stall_hold",   mk(1, 0, 16'h0, 0, 26'd0, 32'hA0, 1, 0, 32'd1, 32'd1, 32'd1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all("rst_in_stall", rst_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
